// File: rtl/pic_pkg.sv
// Shared definitions for the 8-level interrupt priority sequencer.
//   seq_state_e      : acknowledge handshake states
//   OCW2_*           : OCW2[7:5] command codes
//   NUM_LEVELS       : number of interrupt levels
//   prio_rank()      : rank of a level for a given lowest-priority pointer (0 = highest)
package pic_pkg;

   localparam int NUM_LEVELS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACK1  = 2'd1,
      ST_WAIT2 = 2'd2,
      ST_ACK2  = 2'd3
   } seq_state_e;

   localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_NOP          = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
   localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
   localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

   // 3-bit wrap gives the modulo-8 distance from the level just above the lowest.
   function automatic logic [2:0] prio_rank(input logic [2:0] level,
                                            input logic [2:0] lowest_ptr);
      return level - lowest_ptr - 3'd1;
   endfunction

endpackage

// File: rtl/priority_resolver.sv
// Rotating priority resolver: picks the set bit of req with the lowest rank.
//   req        : candidate bits, one per level
//   lowest_ptr : level currently holding the lowest priority
//   valid      : at least one candidate bit set
//   level      : winning level (0 when !valid)
module priority_resolver
   import pic_pkg::*;
(
   input  logic [NUM_LEVELS-1:0] req,
   input  logic [2:0]            lowest_ptr,
   output logic                  valid,
   output logic [2:0]            level
);

   logic [2:0] idx;

   // Walk from the lowest rank to the highest so the last hit wins.
   always_comb begin
      valid = 1'b0;
      level = 3'd0;
      idx   = 3'd0;
      for (int r = NUM_LEVELS - 1; r >= 0; r--) begin
         idx = lowest_ptr + 3'd1 + 3'(r);
         if (req[idx]) begin
            valid = 1'b1;
            level = idx;
         end
      end
   end

endmodule

// File: rtl/priority_sequencer.sv
// 8259-style interrupt priority sequencer, 8086 vectoring, 8 fixed levels.
//   clk, reset     : clock, synchronous active-high reset
//   IR, IMR        : request lines and mask (1 = masked)
//   vectorBase     : T7..T3 of the vector byte
//   LTIM, AEOI     : level-trigger mode, automatic EOI
//   OCW2,OCW2Write : command byte and its one-cycle strobe
//   INTA           : active-low acknowledge from the CPU
//   INT            : request to CPU
//   dataOut,dataEnable : vector byte and its drive enable
//   IRR, ISR       : request and in-service registers
//
// state    | meaning
// ST_IDLE  | waiting for first INTA falling edge
// ST_ACK1  | first INTA low; level latched, ISR set
// ST_WAIT2 | between the two INTA pulses
// ST_ACK2  | second INTA low; vector driven
module priority_sequencer
   import pic_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] IR,
   input  logic [7:0] IMR,
   input  logic [4:0] vectorBase,
   input  logic       LTIM,
   input  logic       AEOI,
   input  logic [7:0] OCW2,
   input  logic       OCW2Write,
   input  logic       INTA,
   output logic       INT,
   output logic [7:0] dataOut,
   output logic       dataEnable,
   output logic [7:0] IRR,
   output logic [7:0] ISR
);

   seq_state_e state_q, state_d;
   logic [7:0] irr_q, irr_d, isr_q, isr_d, ir_prev_q, ir_prev_d;
   logic [7:0] data_out_q, data_out_d;
   logic [2:0] lowest_ptr_q, lowest_ptr_d, level_q, level_d;
   logic       rot_aeoi_q, rot_aeoi_d, spurious_q, spurious_d;
   logic       inta_prev_q, inta_prev_d, data_en_q, data_en_d;

   logic [7:0] irr_req, irr_next, set_mask, eoi_clr, aeoi_clr;
   logic       irr_valid, isr_valid, inta_fall, inta_rise;
   logic [2:0] irr_level, isr_level, ocw2_cmd, ocw2_lvl;
   logic       unused_ocw2;

   assign irr_req     = irr_q & ~IMR;
   assign ocw2_cmd    = OCW2[7:5];
   assign ocw2_lvl    = OCW2[2:0];
   assign unused_ocw2 = ^OCW2[4:3];

   priority_resolver u_irr_res (.req(irr_req), .lowest_ptr(lowest_ptr_q),
                                .valid(irr_valid), .level(irr_level));
   priority_resolver u_isr_res (.req(isr_q), .lowest_ptr(lowest_ptr_q),
                                .valid(isr_valid), .level(isr_level));

   // Comparing against the best in-service level is enough: it outranks every other ISR bit.
   assign INT = irr_valid &&
                (!isr_valid || (prio_rank(irr_level, lowest_ptr_q) < prio_rank(isr_level, lowest_ptr_q)));

   assign dataOut    = data_out_q;
   assign dataEnable = data_en_q;
   assign IRR        = irr_q;
   assign ISR        = isr_q;

   always_comb begin
      inta_fall    = inta_prev_q & ~INTA;
      inta_rise    = ~inta_prev_q & INTA;
      state_d      = state_q;
      level_d      = level_q;
      spurious_d   = spurious_q;
      lowest_ptr_d = lowest_ptr_q;
      rot_aeoi_d   = rot_aeoi_q;
      set_mask     = 8'h00;
      eoi_clr      = 8'h00;
      aeoi_clr     = 8'h00;

      case (state_q)
         ST_IDLE: if (inta_fall) begin
            state_d = ST_ACK1;
            if (irr_valid) begin
               level_d    = irr_level;
               spurious_d = 1'b0;
               set_mask   = 8'h01 << irr_level;
            end else begin
               level_d    = 3'd7;
               spurious_d = 1'b1;
            end
         end
         ST_ACK1:  if (inta_rise) state_d = ST_WAIT2;
         ST_WAIT2: if (inta_fall) state_d = ST_ACK2;
         ST_ACK2: if (inta_rise) begin
            state_d = ST_IDLE;
            if (AEOI && !spurious_q) begin
               aeoi_clr = 8'h01 << level_q;
               if (rot_aeoi_q) lowest_ptr_d = level_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A pointer written by OCW2 overrides a same-cycle AEOI rotation.
      if (OCW2Write) begin
         case (ocw2_cmd)
            OCW2_NS_EOI: if (isr_valid) eoi_clr = 8'h01 << isr_level;
            OCW2_SP_EOI: eoi_clr = 8'h01 << ocw2_lvl;
            OCW2_ROT_NS_EOI: if (isr_valid) begin
               eoi_clr      = 8'h01 << isr_level;
               lowest_ptr_d = isr_level;
            end
            OCW2_ROT_SP_EOI: if (isr_valid) begin
               eoi_clr      = 8'h01 << ocw2_lvl;
               lowest_ptr_d = ocw2_lvl;
            end
            OCW2_SET_PRIO:     lowest_ptr_d = ocw2_lvl;
            OCW2_SET_ROT_AEOI: rot_aeoi_d   = 1'b1;
            OCW2_CLR_ROT_AEOI: rot_aeoi_d   = 1'b0;
            default: ;
         endcase
      end

      // Edge mode holds a request only while the line stays high.
      irr_next    = LTIM ? IR : ((irr_q | (IR & ~ir_prev_q)) & IR);
      irr_d       = irr_next & ~set_mask;
      isr_d       = (isr_q & ~(eoi_clr | aeoi_clr)) | set_mask;
      ir_prev_d   = IR;
      inta_prev_d = INTA;
      data_en_d   = (state_d == ST_ACK2);
      data_out_d  = data_en_d ? {vectorBase, level_d} : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         irr_q        <= 8'h00;
         isr_q        <= 8'h00;
         ir_prev_q    <= 8'h00;
         inta_prev_q  <= 1'b1;
         lowest_ptr_q <= 3'd7;
         rot_aeoi_q   <= 1'b0;
         level_q      <= 3'd0;
         spurious_q   <= 1'b0;
         data_out_q   <= 8'h00;
         data_en_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         irr_q        <= irr_d;
         isr_q        <= isr_d;
         ir_prev_q    <= ir_prev_d;
         inta_prev_q  <= inta_prev_d;
         lowest_ptr_q <= lowest_ptr_d;
         rot_aeoi_q   <= rot_aeoi_d;
         level_q      <= level_d;
         spurious_q   <= spurious_d;
         data_out_q   <= data_out_d;
         data_en_q    <= data_en_d;
      end
   end

endmodule

// File: tb/tb_priority_sequencer.sv
// Bench for priority_sequencer: behavioural model + vector scoreboard,
// directed scenarios followed by randomized traffic.
module tb_priority_sequencer;

   logic       clk = 1'b0;
   logic       reset, LTIM, AEOI, OCW2Write, INTA, INT, dataEnable;
   logic [7:0] IR, IMR, OCW2, dataOut, IRR, ISR;
   logic [4:0] vectorBase;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   priority_sequencer dut (
      .clk(clk), .reset(reset), .IR(IR), .IMR(IMR), .vectorBase(vectorBase),
      .LTIM(LTIM), .AEOI(AEOI), .OCW2(OCW2), .OCW2Write(OCW2Write), .INTA(INTA),
      .INT(INT), .dataOut(dataOut), .dataEnable(dataEnable), .IRR(IRR), .ISR(ISR)
   );

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_irr = 8'h00, m_isr = 8'h00, m_prev_ir = 8'h00;
   logic       m_prev_inta = 1'b1, m_rot = 1'b0, m_spur = 1'b0;
   int         m_ptr = 7, m_hs = 0, m_lvl = 0;
   logic [7:0] exp_q[$];

   logic [7:0] t_set, t_clr, t_irr_new;
   logic       t_fall, t_rise;
   int         t_w, t_b, t_ptr;

   // Highest-priority set level, or -1.
   function automatic int best(input logic [7:0] bits, input int ptr);
      for (int k = 0; k < 8; k++)
         if (bits[(ptr + 1 + k) % 8]) return (ptr + 1 + k) % 8;
      return -1;
   endfunction

   function automatic int rank_of(input int n, input int ptr);
      return (n - ptr - 1 + 16) % 8;
   endfunction

   function automatic logic model_int();
      int w, b;
      w = best(m_irr & ~IMR, m_ptr);
      b = best(m_isr, m_ptr);
      return (w >= 0) && ((b < 0) || (rank_of(w, m_ptr) < rank_of(b, m_ptr)));
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_irr = 8'h00; m_isr = 8'h00; m_prev_ir = 8'h00; m_prev_inta = 1'b1;
         m_ptr = 7; m_rot = 1'b0; m_hs = 0; m_lvl = 0; m_spur = 1'b0;
      end else begin
         t_fall = m_prev_inta && !INTA;
         t_rise = !m_prev_inta && INTA;
         t_set = 8'h00; t_clr = 8'h00; t_ptr = m_ptr;
         t_irr_new = LTIM ? IR : ((m_irr | (IR & ~m_prev_ir)) & IR);
         // m_hs counts handshake progress: 0 idle, 1 first low, 2 between, 3 second low
         case (m_hs)
            0: if (t_fall) begin
               t_w = best(m_irr & ~IMR, m_ptr);
               if (t_w >= 0) begin m_lvl = t_w; m_spur = 1'b0; t_set[t_w] = 1'b1; end
               else begin m_lvl = 7; m_spur = 1'b1; end
               m_hs = 1;
            end
            1: if (t_rise) m_hs = 2;
            2: if (t_fall) begin
               m_hs = 3;
               exp_q.push_back({vectorBase, 3'(m_lvl)});
            end
            default: if (t_rise) begin
               m_hs = 0;
               if (AEOI && !m_spur) begin
                  t_clr[m_lvl] = 1'b1;
                  if (m_rot) t_ptr = m_lvl;
               end
            end
         endcase
         if (OCW2Write) begin
            t_b = best(m_isr, m_ptr);
            case (OCW2[7:5])
               3'd0: m_rot = 1'b0;
               3'd1: if (t_b >= 0) t_clr[t_b] = 1'b1;
               3'd3: t_clr[OCW2[2:0]] = 1'b1;
               3'd4: m_rot = 1'b1;
               3'd5: if (t_b >= 0) begin t_clr[t_b] = 1'b1; t_ptr = t_b; end
               3'd6: t_ptr = int'(OCW2[2:0]);
               3'd7: if (m_isr != 8'h00) begin t_clr[OCW2[2:0]] = 1'b1; t_ptr = int'(OCW2[2:0]); end
               default: ;
            endcase
         end
         m_isr = (m_isr & ~t_clr) | t_set;
         m_irr = t_irr_new & ~t_set;
         m_ptr = t_ptr;
         m_prev_ir = IR;
         m_prev_inta = INTA;
      end
   end

   // ---------------- monitor ----------------
   logic mon_prev_de = 1'b0;
   logic [7:0] mon_exp;

   always @(posedge clk) begin
      #1;
      chk8("irr", IRR, m_irr);
      chk8("isr", ISR, m_isr);
      chk1("int", INT, model_int());
      chk1("data_enable", dataEnable, m_hs == 3);
      if (!dataEnable) chk8("data_out_idle", dataOut, 8'h00);
      if (dataEnable && !mon_prev_de) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL vector_unexpected: got %02h expected none at %0t", dataOut, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            chk8("vector", dataOut, mon_exp);
         end
      end
      mon_prev_de = dataEnable;
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; IR = 8'h00; INTA = 1'b1; OCW2Write = 1'b0; OCW2 = 8'h00;
      cyc(1);
      reset = 1'b0;
   endtask

   task automatic ocw2_write(input logic [7:0] v);
      OCW2 = v; OCW2Write = 1'b1;
      cyc(1);
      OCW2Write = 1'b0;
   endtask

   task automatic ack1();
      INTA = 1'b0; cyc(2);
      INTA = 1'b1; cyc(2);
   endtask

   task automatic ack2_fall();
      INTA = 1'b0; cyc(1);
   endtask

   task automatic ack2_rise();
      INTA = 1'b1; cyc(2);
   endtask

   task automatic rcyc(input int n);
      repeat (n) begin
         if ($urandom_range(0, 2) == 0) IR = 8'($urandom);
         IMR = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         if ($urandom_range(0, 5) == 0) begin
            OCW2 = {3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))};
            OCW2Write = 1'b1;
         end
         @(negedge clk);
         OCW2Write = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; IR = 8'h00; IMR = 8'h00; vectorBase = 5'h08; LTIM = 1'b0;
      AEOI = 1'b0; OCW2 = 8'h00; OCW2Write = 1'b0; INTA = 1'b1;
      cyc(2);
      do_reset();
      chk8("reset_irr", IRR, 8'h00);
      chk8("reset_isr", ISR, 8'h00);
      chk1("reset_int", INT, 1'b0);
      chk1("reset_de", dataEnable, 1'b0);
      chk8("reset_dout", dataOut, 8'h00);

      // Basic two-pulse acknowledge with pending lower level
      IR = 8'h05; cyc(2);
      chk8("basic_irr", IRR, 8'h05);
      chk1("basic_int_req", INT, 1'b1);
      ack1();
      chk8("basic_isr", ISR, 8'h01);
      chk8("basic_irr_after", IRR, 8'h04);
      ack2_fall();
      chk8("basic_vector", dataOut, 8'h40);
      ack2_rise();
      chk1("basic_int_nested", INT, 1'b0);
      ocw2_write(8'h20);
      chk8("basic_isr_eoi", ISR, 8'h00);
      chk1("basic_int_eoi", INT, 1'b1);

      // Automatic EOI
      do_reset(); AEOI = 1'b1;
      IR = 8'h08; cyc(2);
      ack1(); ack2_fall();
      chk8("aeoi_vector", dataOut, 8'h43);
      chk1("aeoi_de", dataEnable, 1'b1);
      ack2_rise();
      chk8("aeoi_isr", ISR, 8'h00);
      AEOI = 1'b0;

      // Set priority: lowest = 2, so IR3 outranks IR0
      do_reset();
      ocw2_write(8'hC2);
      IR = 8'h09; cyc(2);
      ack1(); ack2_fall();
      chk8("setprio_vector", dataOut, 8'h43);
      ack2_rise();

      // Withdrawn edge request -> spurious
      do_reset();
      IR = 8'h01; cyc(2);
      chk8("spur_irr_set", IRR, 8'h01);
      IR = 8'h00; cyc(2);
      chk8("spur_irr_clr", IRR, 8'h00);
      ack1();
      chk8("spur_isr", ISR, 8'h00);
      ack2_fall();
      chk8("spur_vector", dataOut, 8'h47);
      ack2_rise();
      chk8("spur_isr_end", ISR, 8'h00);

      // Nesting
      do_reset();
      IR = 8'h10; cyc(2);
      ack1(); ack2_fall(); ack2_rise();
      chk8("nest_isr", ISR, 8'h10);
      IR = 8'h12; cyc(2);
      chk1("nest_int_hi", INT, 1'b1);
      IR = 8'h50; cyc(2);
      chk1("nest_int_lo", INT, 1'b0);
      ocw2_write(8'h64);
      chk8("nest_isr_eoi", ISR, 8'h00);
      chk1("nest_int_after", INT, 1'b1);

      // Reset in WAIT2
      do_reset();
      IR = 8'h01; cyc(2);
      ack1();
      reset = 1'b1; cyc(1);
      chk1("rst_wait2_de", dataEnable, 1'b0);
      chk8("rst_wait2_isr", ISR, 8'h00);
      reset = 1'b0; INTA = 1'b0; cyc(1);
      chk1("rst_wait2_no_ack2", dataEnable, 1'b0);
      INTA = 1'b1; cyc(2);
      ack2_fall();
      chk8("rst_wait2_vector", dataOut, 8'h47);
      ack2_rise();

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         if (it % 60 == 0) begin
            do_reset();
            LTIM = 1'($urandom_range(0, 1));
            AEOI = 1'($urandom_range(0, 1));
            vectorBase = 5'($urandom);
         end
         rcyc($urandom_range(1, 4));
         INTA = 1'b0; rcyc($urandom_range(1, 3));
         INTA = 1'b1; rcyc($urandom_range(1, 3));
         INTA = 1'b0; rcyc($urandom_range(1, 3));
         INTA = 1'b1; rcyc($urandom_range(1, 3));
      end
      cyc(3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL vector_missing: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
